// File: rtl/des_round_scheduler.sv
// des_round_scheduler
//   Iterative DES round controller placed between the IP and FP stages. One
//   shared 2-stage pipelined round function is kept busy by interleaving two
//   independent block contexts (slot 0 / slot 1). Slot p owns the round
//   function on cycles where phase == p. Subkeys are requested from an
//   external store each issued round; the final L/R swap is applied on capture.
//
//   Optional error checker: define DES_ROUND_SCHED_ERRCHK_EN to build the
//   sticky protocol checker driving err; otherwise err is tied low.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous abort of all in-flight blocks
//   in_valid/in_ready    input block handshake; in_decrypt, in_L, in_R payload
//   out_valid/out_ready  result handshake; out_L = R16, out_R = L16
//   subkey_sel, subkey   subkey request index and combinational response
//   rf_*                 round-function control, data and key
//   err                  sticky protocol error
//
// Slot states
//   state  | meaning
//   S_IDLE | empty, may accept a block on its owned phase
//   S_RUN  | block in flight, one round outstanding in the round function
//   S_DONE | swapped result held until the output handshake
module des_round_scheduler #(
  parameter int NUM_ROUNDS = 16,
  parameter int SEL_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_decrypt,
  input  logic [31:0]      in_L,
  input  logic [31:0]      in_R,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_L,
  output logic [31:0]      out_R,
  output logic [SEL_W-1:0] subkey_sel,
  input  logic [47:0]      subkey,
  output logic             rf_i_valid,
  output logic             rf_enable,
  output logic             rf_restart_block,
  output logic [31:0]      rf_L_in,
  output logic [31:0]      rf_R_in,
  output logic [47:0]      rf_Kn,
  input  logic             rf_o_valid,
  input  logic [31:0]      rf_L_out,
  input  logic [31:0]      rf_R_out,
  output logic             err
);

  localparam logic [4:0] LP_NR = 5'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } slot_st_t;

  slot_st_t    r_st    [2];
  logic [4:0]  r_rnd   [2];
  logic        r_mode  [2];
  logic [31:0] r_res_l [2];
  logic [31:0] r_res_r [2];
  logic        r_phase;
  logic        r_oldest;
  logic        r_init;

  logic        w_p;
  logic        w_q;
  logic        w_accept;
  logic        w_rf_done;
  logic        w_last;
  logic        w_reissue;
  logic        w_capture;
  logic        w_out_hs;
  logic [4:0]  w_iss_rnd;
  logic        w_iss_mode;
  logic [4:0]  w_sel;

  assign w_p = r_phase;
  assign w_q = ~r_phase;

  // r_init holds in_ready low during the init cycle, when the round function
  // is being restarted and would drop anything issued to it.
  assign in_ready  = !r_init && !flush && (r_st[w_p] == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_rf_done = !flush && rf_o_valid && (r_st[w_p] == S_RUN);
  assign w_last    = (r_rnd[w_p] >= LP_NR);
  assign w_reissue = w_rf_done && !w_last;
  assign w_capture = w_rf_done && w_last;

  assign out_valid = (r_st[0] == S_DONE) || (r_st[1] == S_DONE);
  assign w_out_hs  = out_valid && out_ready && !flush;
  assign out_L     = r_res_l[r_oldest];
  assign out_R     = r_res_r[r_oldest];

  assign rf_enable        = rst_n;
  assign rf_restart_block = rst_n && (r_init || flush);
  assign rf_Kn            = subkey;

  always_comb begin
    rf_i_valid = 1'b0;
    rf_L_in    = rf_L_out;
    rf_R_in    = rf_R_out;
    w_iss_rnd  = r_rnd[w_p] + 5'd1;
    w_iss_mode = r_mode[w_p];
    if (w_accept) begin
      rf_i_valid = 1'b1;
      rf_L_in    = in_L;
      rf_R_in    = in_R;
      w_iss_rnd  = 5'd1;
      w_iss_mode = in_decrypt;
    end else if (w_reissue) begin
      rf_i_valid = 1'b1;
    end
  end

  // Decrypt walks the same subkey store backwards.
  assign w_sel      = w_iss_mode ? (LP_NR - w_iss_rnd) : (w_iss_rnd - 5'd1);
  assign subkey_sel = SEL_W'(w_sel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_st[i]    <= S_IDLE;
        r_rnd[i]   <= 5'd0;
        r_mode[i]  <= 1'b0;
        r_res_l[i] <= 32'd0;
        r_res_r[i] <= 32'd0;
      end
      r_phase  <= 1'b0;
      r_oldest <= 1'b0;
      r_init   <= 1'b1;
    end else begin
      r_phase <= ~r_phase;
      r_init  <= 1'b0;
      if (flush) begin
        r_st[0]  <= S_IDLE;
        r_st[1]  <= S_IDLE;
        r_oldest <= 1'b0;
      end else begin
        if (w_accept) begin
          r_st[w_p]   <= S_RUN;
          r_rnd[w_p]  <= 5'd1;
          r_mode[w_p] <= in_decrypt;
          // With the other slot empty this block becomes the oldest one.
          if (r_st[w_q] == S_IDLE) begin
            r_oldest <= w_p;
          end
        end
        if (w_reissue) begin
          r_rnd[w_p] <= w_iss_rnd;
        end
        if (w_capture) begin
          r_st[w_p]    <= S_DONE;
          r_res_l[w_p] <= rf_R_out;
          r_res_r[w_p] <= rf_L_out;
        end
        // The retiring slot is always DONE, so it never collides with the
        // accepting or capturing slot; an accept in the same cycle goes to
        // the other slot, which the flip points at.
        if (w_out_hs) begin
          r_st[r_oldest] <= S_IDLE;
          r_oldest       <= ~r_oldest;
        end
      end
    end
  end

`ifdef DES_ROUND_SCHED_ERRCHK_EN
  logic r_err;

  // On its owned phase a RUN slot always has a result due (issued two cycles
  // earlier), and any other slot state must see no result at all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (flush) begin
      r_err <= 1'b0;
    end else if (rf_o_valid != (r_st[w_p] == S_RUN)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule
